// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential lookahead divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Iteration counter must hold WIDTH itself.
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  localparam logic [DEFAULT_WIDTH-1:0] DBZ_QUOT_DEFAULT = '1;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Combinational a - b using chained 4-bit carry-lookahead slices (b inverted, carry-in 1).
module cla_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             cout_o
);
  localparam int NS = WIDTH / 4;

  logic [WIDTH-1:0] bn, p, g;
  logic [NS:0]      c;

  assign bn   = ~b_i;
  assign p    = a_i ^ bn;
  assign g    = a_i & bn;
  assign c[0] = 1'b1;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    logic [3:0] pp, gg, cc;
    logic       grp_g, grp_p;

    assign pp    = p[4*s +: 4];
    assign gg    = g[4*s +: 4];
    assign cc[0] = c[s];
    assign cc[1] = gg[0] | (pp[0] & cc[0]);
    assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
    assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                 | (pp[2] & pp[1] & pp[0] & cc[0]);
    assign grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                 | (pp[3] & pp[2] & pp[1] & gg[0]);
    assign grp_p = &pp;
    assign c[s+1] = grp_g | (grp_p & c[s]);
    assign diff_o[4*s +: 4] = pp ^ cc;
  end

  assign cout_o = c[NS];

endmodule

// File: rtl/seq_cla_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero).
module seq_cla_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] DBZ_QUOT = '1;

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic             dbz_q;
  logic             busy_q, done_q, dbz_out_q;
  logic [WIDTH-1:0] quot_out_q, rem_out_q;

  logic [WIDTH-1:0] a_abs, b_abs, fin_quo, fin_rem;
  logic [WIDTH-1:0] r_sh, diff;
  logic             cout, take;

`ifdef DIV_SIGNED_EN
  logic neg_q_q, neg_r_q;

  assign a_abs   = dividend[WIDTH-1] ? -dividend : dividend;
  assign b_abs   = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign fin_quo = (neg_q_q && !dbz_q) ? -quo_q : quo_q;
  assign fin_rem = (neg_r_q && !dbz_q) ? -rem_q : rem_q;
`else
  assign a_abs   = dividend;
  assign b_abs   = divisor;
  assign fin_quo = quo_q;
  assign fin_rem = rem_q;
`endif

  assign r_sh = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

  cla_subtractor #(.WIDTH(WIDTH)) u_sub (
    .a_i   (r_sh),
    .b_i   (dsr_q),
    .diff_o(diff),
    .cout_o(cout)
  );

  // The bit shifted out of the remainder is an implicit 2^WIDTH: when set the
  // trial can never borrow, and the low WIDTH bits of the difference are exact.
  assign take = cout | rem_q[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_out_q  <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
`ifdef DIV_SIGNED_EN
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            dsr_q  <= b_abs;
`ifdef DIV_SIGNED_EN
            neg_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r_q <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
              quo_q   <= DBZ_QUOT;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              state_q <= FIN;
            end else begin
              quo_q   <= a_abs;
              rem_q   <= '0;
              dbz_q   <= 1'b0;
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= take ? diff : r_sh;
          quo_q <= {quo_q[WIDTH-2:0], take};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_q <= FIN;
        end
        FIN: begin
          quot_out_q <= fin_quo;
          rem_out_q  <= fin_rem;
          dbz_out_q  <= dbz_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_cla_divider.sv
// Directed self-checking bench for seq_cla_divider (WIDTH=8).
module tb_seq_cla_divider;
  logic       clk = 1'b0;
  logic       rst, start, busy, done, div_by_zero;
  logic [7:0] dividend, divisor, quotient, remainder;
  int         checks = 0;
  int         errors = 0;

  seq_cla_divider #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts at the next edge (E0), returns #1 after the edge where done is seen.
  task automatic div(input logic [7:0] a, input logic [7:0] b, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic res(input string tag, input int lat, input int elat,
                     input logic [7:0] q, input logic [7:0] r, input logic z);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, quotient, q);
    chk({tag, "_r"}, remainder, r);
    chk({tag, "_z"}, div_by_zero, z);
  endtask

  initial begin
    int lat, gap, pulses;
    logic [7:0] a, b;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_z", div_by_zero, 0);
    rst = 1'b0;
    step();

`ifdef DIV_SIGNED_EN
    div(8'h9C, 8'd7, lat);   res("sn100_7", lat, 9, 8'hF2, 8'hFE, 0);
    div(8'd100, 8'hF9, lat); res("s100_n7", lat, 9, 8'hF2, 8'h02, 0);
    div(8'h80, 8'hFF, lat);  res("smin_n1", lat, 9, 8'h80, 8'h00, 0);
    div(8'hFB, 8'h00, lat);  res("sdbz", lat, 1, 8'hFF, 8'hFB, 1);
    div(8'd100, 8'd7, lat);  res("s100_7", lat, 9, 8'd14, 8'd2, 0);
`else
    div(8'd255, 8'd1, lat); res("255_1", lat, 9, 8'd255, 8'd0, 0);

    // 100/7 with busy tracked across every edge and the old result held
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    step();
    start = 1'b0;
    chk("hold_q", quotient, 8'd255);
    for (int i = 1; i <= 8; i++) begin
      chk("busy_calc", busy, 1);
      step();
    end
    chk("busy_fin", busy, 1);
    chk("done_early", done, 0);
    step();
    chk("done_e9", done, 1);
    chk("busy_e9", busy, 0);
    res("100_7", 9, 9, 8'd14, 8'd2, 0);
    step();
    chk("done_pulse", done, 0);

    div(8'd5, 8'd9, lat);  res("5_9", lat, 9, 8'd0, 8'd5, 0);
    div(8'd42, 8'd0, lat); res("42_0", lat, 1, 8'hFF, 8'd42, 1);
    div(8'd42, 8'd6, lat); res("42_6", lat, 9, 8'd7, 8'd0, 0);
    div(8'd255, 8'd200, lat); res("255_200", lat, 9, 8'd1, 8'd55, 0);

    for (int n = 0; n < 16; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      div(a, b, lat);
      chk("rnd_lat", lat, 9);
      chk("rnd_inv", 16'(quotient) * 16'(b) + 16'(remainder), 16'(a));
      chk("rnd_rlt", remainder < b, 1);
    end

    // start pulsed at E3 with other operands must be ignored
    dividend = 8'd200; divisor = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    dividend = 8'd9; divisor = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    lat = 3;
    while (!done && lat < 40) begin step(); lat++; end
    res("200_3", lat, 9, 8'd66, 8'd2, 0);

    // start held high: back-to-back, done pulses 10 edges apart
    div(8'd50, 8'd7, lat);
    start = 1'b1;
    step();
    chk("b2b_busy", busy, 1);
    gap = 1;
    while (!done && gap < 40) begin step(); gap++; end
    start = 1'b0;
    chk("b2b_gap", gap, 10);
    res("b2b_50_7", 9, 9, 8'd7, 8'd1, 0);

    // async reset mid-CALC, between edges
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_q", quotient, 0);
    chk("mrst_r", remainder, 0);
    chk("mrst_z", div_by_zero, 0);
    step();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) pulses++;
    end
    chk("mrst_nodone", pulses, 0);
    div(8'd13, 8'd4, lat); res("13_4", lat, 9, 8'd3, 8'd1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
